// File: rtl/usart_baud_gen.sv
// usart_baud_gen: USART baud-rate prescaler and XCK clock generation.
// One shared (UBRRn+1) prescaler feeds the async oversample/bit strobes and
// the sync-master XCK; sync-slave strobes come from the synchronized XCK pin.
// Both strobes are registered, so they appear the cycle after the prescaler
// event and line up with the XCKn_o edge they belong to.
module usart_baud_gen #(
    parameter int UBRR_W = 12
) (
    input  logic              cp2,
    input  logic              ireset,
    input  logic [UBRR_W-1:0] UBRRn,
    input  logic              ubrr_wr,
    input  logic              U2Xn,
    input  logic [1:0]        UMSELn,
    input  logic              UCPOLn,
    input  logic              DDR_XCKn,
    input  logic              XCKn_i,
    input  logic              TXENn,
    input  logic              RXENn,
    output logic              XCKn_o,
    output logic              xck_oe,
    output logic              tx_tick,
    output logic              rx_tick
);

    logic [UBRR_W-1:0] presc_cnt_q, presc_cnt_d;
    logic              presc_arm_q, presc_arm_d;
    logic [3:0]        tx_div_q, tx_div_d;
    logic              xck_int_q, xck_int_d;
    logic [2:0]        xck_sync_q, xck_sync_d;
    logic              xck_o_q, xck_o_d;
    logic              xck_oe_q, xck_oe_d;
    logic              tx_tick_q, tx_tick_d;
    logic              rx_tick_q, rx_tick_d;

    logic run, async_mode, sync_master, sync_slave;
    logic presc_tick, tx_wrap, xck_next, pin_rise, pin_fall;

    assign run         = (TXENn | RXENn) & ~UMSELn[1];
    assign async_mode  = (UMSELn == 2'b00);
    assign sync_master = (UMSELn == 2'b01) & DDR_XCKn;
    assign sync_slave  = (UMSELn == 2'b01) & ~DDR_XCKn;

    // Prescaler: down-count to zero then reload. The arm flag forces one
    // load after reset so the first tick never comes from the reset value 0.
    always_comb begin
        presc_tick  = run & presc_arm_q & ~ubrr_wr & (presc_cnt_q == '0);
        presc_arm_d = 1'b1;
        if (!run || !presc_arm_q || ubrr_wr || presc_tick)
            presc_cnt_d = UBRRn;
        else
            presc_cnt_d = presc_cnt_q - {{(UBRR_W-1){1'b0}}, 1'b1};
    end

    // Async bit divider: 16 (or 8 with U2Xn) prescaler ticks per tx bit.
    always_comb begin
        tx_wrap  = U2Xn ? (tx_div_q[2:0] == 3'd7) : (tx_div_q == 4'd15);
        tx_div_d = tx_div_q;
        if (!run)
            tx_div_d = 4'd0;
        else if (async_mode && presc_tick)
            tx_div_d = tx_div_q + 4'd1;
    end

    // XCK: master toggles on prescaler ticks and idles at UCPOLn otherwise;
    // the pin path is two sync stages plus one history stage for edge detect.
    always_comb begin
        xck_sync_d = {xck_sync_q[1:0], XCKn_i};
        pin_rise   = xck_sync_q[1] & ~xck_sync_q[2];
        pin_fall   = ~xck_sync_q[1] & xck_sync_q[2];
        xck_next   = ~xck_int_q;
        if (!sync_master)
            xck_int_d = UCPOLn;
        else if (presc_tick)
            xck_int_d = xck_next;
        else
            xck_int_d = xck_int_q;
        xck_o_d  = sync_master & xck_int_d;
        xck_oe_d = sync_master;
    end

    // Strobe selection per mode; the edge leaving UCPOLn idle level is the
    // transmit edge, the edge returning to it is the sample edge.
    always_comb begin
        tx_tick_d = 1'b0;
        rx_tick_d = 1'b0;
        if (run) begin
            if (async_mode) begin
                rx_tick_d = presc_tick;
                tx_tick_d = presc_tick & tx_wrap;
            end else if (sync_master) begin
                tx_tick_d = presc_tick & (xck_next ^ UCPOLn);
                rx_tick_d = presc_tick & ~(xck_next ^ UCPOLn);
            end else if (sync_slave) begin
                tx_tick_d = UCPOLn ? pin_fall : pin_rise;
                rx_tick_d = UCPOLn ? pin_rise : pin_fall;
            end
        end
    end

    // State registers.
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            presc_cnt_q <= '0;
            presc_arm_q <= 1'b0;
            tx_div_q    <= 4'd0;
            xck_int_q   <= 1'b0;
            xck_sync_q  <= 3'b000;
            xck_o_q     <= 1'b0;
            xck_oe_q    <= 1'b0;
            tx_tick_q   <= 1'b0;
            rx_tick_q   <= 1'b0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
            presc_arm_q <= presc_arm_d;
            tx_div_q    <= tx_div_d;
            xck_int_q   <= xck_int_d;
            xck_sync_q  <= xck_sync_d;
            xck_o_q     <= xck_o_d;
            xck_oe_q    <= xck_oe_d;
            tx_tick_q   <= tx_tick_d;
            rx_tick_q   <= rx_tick_d;
        end
    end

    assign XCKn_o  = xck_o_q;
    assign xck_oe  = xck_oe_q;
    assign tx_tick = tx_tick_q;
    assign rx_tick = rx_tick_q;

endmodule

// File: tb/tb_usart_baud_gen.sv
// tb_usart_baud_gen: directed stimulus for usart_baud_gen with a timing
// model (absolute-cycle prescaler schedule) checked every cycle, plus
// literal period/latency expectations.
module tb_usart_baud_gen;
    localparam int UBRR_W = 12;

    logic              cp2      = 1'b0;
    logic              ireset   = 1'b0;
    logic [UBRR_W-1:0] UBRRn    = '0;
    logic              ubrr_wr  = 1'b0;
    logic              U2Xn     = 1'b0;
    logic [1:0]        UMSELn   = 2'b00;
    logic              UCPOLn   = 1'b0;
    logic              DDR_XCKn = 1'b0;
    logic              XCKn_i   = 1'b0;
    logic              TXENn    = 1'b0;
    logic              RXENn    = 1'b0;
    logic              XCKn_o, xck_oe, tx_tick, rx_tick;

    always #5 cp2 = ~cp2;

    usart_baud_gen #(.UBRR_W(UBRR_W)) dut (
        .cp2(cp2), .ireset(ireset), .UBRRn(UBRRn), .ubrr_wr(ubrr_wr),
        .U2Xn(U2Xn), .UMSELn(UMSELn), .UCPOLn(UCPOLn), .DDR_XCKn(DDR_XCKn),
        .XCKn_i(XCKn_i), .TXENn(TXENn), .RXENn(RXENn),
        .XCKn_o(XCKn_o), .xck_oe(xck_oe), .tx_tick(tx_tick), .rx_tick(rx_tick)
    );

    int vectors = 0, miscompares = 0, cyc = 0;

    // model state
    int next_tick = 0, pcount = 0;
    bit armed = 0, lvl = 0, e_tx = 0, e_rx = 0, e_xo = 0, e_oe = 0;
    bit [2:0] hist = 3'b000;

    // measurements taken from observed outputs
    int rx_last = 0, tx_last = 0, xco_last = 0, rx_per = 0, tx_per = 0, xco_per = 0;
    int rx_cnt = 0, tx_cnt = 0, tx_off_rise = 0, rx_off_fall = 0;
    bit xco_prev = 0;

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge cp2);
        #2;
    endtask

    task automatic wait_rx(input int budget, output int steps);
        steps = 0;
        do begin
            step(1);
            steps++;
        end while (rx_tick !== 1'b1 && steps < budget);
    endtask

    // Model: each rising edge computes what the outputs must be after it.
    // The prescaler is a schedule of absolute tick cycles: a load in cycle n
    // (reset-arm, ubrr_wr, Run low, or a tick) puts the next tick at n+UBRRn+1.
    initial begin : model
        bit run, master, slave, pt, rise, fall;
        forever begin
            @(posedge cp2);
            cyc++;
            if (!ireset) begin
                armed = 0; pcount = 0; lvl = 0; hist = 3'b000;
                e_tx = 0; e_rx = 0; e_xo = 0; e_oe = 0;
            end else begin
                run    = (TXENn || RXENn) && !UMSELn[1];
                master = (UMSELn == 2'b01) && DDR_XCKn;
                slave  = (UMSELn == 2'b01) && !DDR_XCKn;
                pt = 0;
                if (!armed || ubrr_wr || !run) begin
                    next_tick = cyc + int'(UBRRn) + 1;
                end else if (cyc == next_tick) begin
                    pt = 1;
                    next_tick = cyc + int'(UBRRn) + 1;
                end
                armed = 1;
                e_tx = 0; e_rx = 0;
                if (!run) begin
                    pcount = 0;
                end else if (UMSELn == 2'b00 && pt) begin
                    e_rx = 1;
                    e_tx = U2Xn ? (pcount % 8 == 7) : (pcount == 15);
                    pcount = (pcount + 1) % 16;
                end
                if (master) begin
                    if (pt) begin
                        lvl = !lvl;
                        if (lvl != UCPOLn) e_tx = 1; else e_rx = 1;
                    end
                end else begin
                    lvl = UCPOLn;
                end
                if (slave && run) begin
                    // pin level seen 2 and 3 edges ago: tick lands 3 cycles after the pin edge
                    rise = hist[1] && !hist[2];
                    fall = !hist[1] && hist[2];
                    e_tx = UCPOLn ? fall : rise;
                    e_rx = UCPOLn ? rise : fall;
                end
                hist = {hist[1:0], XCKn_i};
                e_xo = master && lvl;
                e_oe = master;
            end
        end
    end

    // Compare every cycle on the falling edge, and record periods.
    initial begin : compare
        logic [3:0] exp, got;
        forever begin
            @(negedge cp2);
            exp = ireset ? {e_tx, e_rx, e_xo, e_oe} : 4'b0000;
            got = {tx_tick, rx_tick, XCKn_o, xck_oe};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                if (miscompares <= 20)
                    $display("FAIL model_cmp cyc=%0d tx/rx/xck/oe got %b required %b", cyc, got, exp);
            end
            if (rx_tick === 1'b1) begin rx_per = cyc - rx_last; rx_last = cyc; rx_cnt++; end
            if (tx_tick === 1'b1) begin tx_per = cyc - tx_last; tx_last = cyc; tx_cnt++; end
            if (XCKn_o === 1'b1 && !xco_prev) begin xco_per = cyc - xco_last; xco_last = cyc; end
            if (tx_tick === 1'b1 && !(XCKn_o === 1'b1 && !xco_prev)) tx_off_rise++;
            if (rx_tick === 1'b1 && !(XCKn_o === 1'b0 && xco_prev)) rx_off_fall++;
            xco_prev = (XCKn_o === 1'b1);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int s, t0, r0, o_tx, o_rx, stray;
        string nm;
        step(2);
        check("reset_tx_tick", int'(tx_tick), 0);
        check("reset_rx_tick", int'(rx_tick), 0);
        check("reset_xckn_o", int'(XCKn_o), 0);
        check("reset_xck_oe", int'(xck_oe), 0);

        // async, UBRRn=129, 16x
        UBRRn = 12'd129; ireset = 1'b1; TXENn = 1'b1;
        wait_rx(300, s);
        check("first_tick_not_before_ubrr_plus_1", int'(s >= 130), 1);
        t0 = tx_cnt;
        for (int i = 0; i < 5000 && tx_cnt < t0 + 2; i++) step(1);
        check("async_rx_period", rx_per, 130);
        check("async_tx_period", tx_per, 2080);

        // double speed without reset
        U2Xn = 1'b1;
        t0 = tx_cnt;
        for (int i = 0; i < 5000 && tx_cnt < t0 + 3; i++) step(1);
        check("async_u2x_tx_period", tx_per, 1040);
        check("async_u2x_rx_period", rx_per, 130);

        // divisor rewrite mid-count: counter is at 60 in the 70th cycle after a tick
        U2Xn = 1'b0;
        wait_rx(200, s);
        step(69);
        UBRRn = 12'd3; ubrr_wr = 1'b1;
        step(1);
        ubrr_wr = 1'b0;
        wait_rx(20, s);
        check("ubrr_wr_next_tick_gap", s, 4);
        r0 = rx_cnt;
        for (int i = 0; i < 50 && rx_cnt < r0 + 3; i++) step(1);
        check("ubrr_wr_new_period", rx_per, 4);

        // sync master, UCPOLn=0
        UMSELn = 2'b01; DDR_XCKn = 1'b1; UCPOLn = 1'b0;
        step(10);
        o_tx = tx_off_rise; o_rx = rx_off_fall;
        step(40);
        check("master_xck_oe", int'(xck_oe), 1);
        check("master_xck_period", xco_per, 8);
        check("master_tx_period", tx_per, 8);
        check("master_rx_period", rx_per, 8);
        check("master_tx_not_on_rise", tx_off_rise - o_tx, 0);
        check("master_rx_not_on_fall", rx_off_fall - o_rx, 0);

        // sync slave, UCPOLn=1, pin period 10 cycles
        DDR_XCKn = 1'b0; UCPOLn = 1'b1;
        step(5);
        for (int h = 0; h < 6; h++) begin
            XCKn_i = ~XCKn_i;
            s = 0;
            for (int j = 1; j <= 5; j++) begin
                step(1);
                if (s == 0 && (XCKn_i ? rx_tick : tx_tick) === 1'b1) s = j;
            end
            if (XCKn_i) nm = "slave_rx_after_pin_rise"; else nm = "slave_tx_after_pin_fall";
            check(nm, s, 3);
        end
        check("slave_xck_oe", int'(xck_oe), 0);
        check("slave_xckn_o", int'(XCKn_o), 0);

        // async UBRRn=0: prescaler every cycle
        UMSELn = 2'b00; UBRRn = 12'd0; ubrr_wr = 1'b1;
        step(1);
        ubrr_wr = 1'b0;
        step(40);
        check("ubrr0_rx_period", rx_per, 1);
        check("ubrr0_tx_period", tx_per, 16);

        // disable mid-count, reset pulse, re-enable
        UBRRn = 12'd9; ubrr_wr = 1'b1;
        step(1);
        ubrr_wr = 1'b0;
        step(25);
        TXENn = 1'b0;
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (tx_tick === 1'b1 || rx_tick === 1'b1) stray++;
        end
        check("ticks_stop_when_disabled", stray, 0);
        ireset = 1'b0;
        #1;
        check("midreset_outputs", int'({tx_tick, rx_tick, XCKn_o, xck_oe}), 0);
        step(3);
        check("held_reset_outputs", int'({tx_tick, rx_tick, XCKn_o, xck_oe}), 0);
        ireset = 1'b1;
        step(2);
        TXENn = 1'b1;
        wait_rx(100, s);
        check("reenable_first_tick_not_early", int'(s >= 10), 1);
        r0 = rx_cnt;
        for (int i = 0; i < 100 && rx_cnt < r0 + 2; i++) step(1);
        check("reenable_rx_period", rx_per, 10);

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
